// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: pipeline-facing signals of the interrupt sequencer.
// master is the pipeline/testbench side, slave is the sequencer.
interface irq_sequencer_if #(
   parameter int W    = 16,
   parameter int PC_W = 32
);
   logic            interrupt;
   logic [PC_W-1:0] fetch_pc;
   logic            branch_pending;
   logic            stall;
   logic [2:0]      flags;
   logic            rti;
   logic            pc_hold;
   logic            inject_valid;
   logic [1:0]      inject_op;
   logic [W-1:0]    push_data;
   logic            vector_load;
   logic [PC_W-1:0] vector_addr;
   logic            irq_ack;
   logic            in_isr;
   logic            flags_restore;
   logic [2:0]      flags_saved;
   modport master (
      output interrupt, fetch_pc, branch_pending, stall, flags, rti,
      input  pc_hold, inject_valid, inject_op, push_data, vector_load, vector_addr,
      input  irq_ack, in_isr, flags_restore, flags_saved
   );
   modport slave (
      input  interrupt, fetch_pc, branch_pending, stall, flags, rti,
      output pc_hold, inject_valid, inject_op, push_data, vector_load, vector_addr,
      output irq_ack, in_isr, flags_restore, flags_saved
   );
endinterface

// File: rtl/irq_sequencer.sv
// irq_sequencer: accepts an edge-triggered interrupt at a safe pipeline boundary,
// injects NOP + two return-PC pushes, then vectors fetch to the ISR pointer.
module irq_sequencer #(
   parameter int W        = 16,
   parameter int PC_W     = 32,
   parameter int VEC_ADDR = 2
) (
   input logic           clk,
   input logic           rst,
   irq_sequencer_if.slave io_bus
);
   typedef enum logic [2:0] {IDLE, PUSH_HI, PUSH_LO, VECTOR, ISR} state_t;
   state_t          r_state;
   logic            r_pending;
   logic            r_interrupt_q;
   logic [PC_W-1:0] r_ret_pc;
   logic [2:0]      r_flags_saved;
   logic            w_rise;
   logic            w_accept;
   logic            w_push;
   logic            w_vec;
   logic            w_isr;
   assign w_rise   = io_bus.interrupt & ~r_interrupt_q;
   assign w_accept = (r_state == IDLE) & r_pending & ~io_bus.branch_pending & ~io_bus.stall;
   assign w_push   = (r_state == PUSH_HI) | (r_state == PUSH_LO);
   assign w_vec    = r_state == VECTOR;
   assign w_isr    = r_state == ISR;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_pending     <= 1'b0;
         r_interrupt_q <= 1'b0;
         r_ret_pc      <= '0;
         r_flags_saved <= '0;
      end else begin
         r_interrupt_q <= io_bus.interrupt;
         // a fresh edge arriving in the acceptance cycle must not be lost
         r_pending     <= w_rise | (r_pending & ~w_accept);
         case (r_state)
            IDLE: if (w_accept) begin
               r_ret_pc      <= io_bus.fetch_pc;
               r_flags_saved <= io_bus.flags;
               r_state       <= PUSH_HI;
            end
            PUSH_HI: if (!io_bus.stall) r_state <= PUSH_LO;
            PUSH_LO: if (!io_bus.stall) r_state <= VECTOR;
            VECTOR:  r_state <= ISR;
            ISR:     if (io_bus.rti) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   assign io_bus.irq_ack       = w_accept;
   assign io_bus.pc_hold       = w_accept | w_push;
   assign io_bus.inject_valid  = w_accept | w_push | w_vec;
   assign io_bus.inject_op     = (r_state == PUSH_HI) ? 2'b01 : (r_state == PUSH_LO) ? 2'b10 : 2'b00;
   assign io_bus.push_data     = (r_state == PUSH_HI) ? r_ret_pc[PC_W-1 -: W] :
                                 (r_state == PUSH_LO) ? r_ret_pc[W-1:0] : '0;
   assign io_bus.vector_load   = w_vec;
   assign io_bus.vector_addr   = w_vec ? PC_W'(VEC_ADDR) : '0;
   assign io_bus.in_isr        = w_isr;
   assign io_bus.flags_restore = w_isr & io_bus.rti;
   assign io_bus.flags_saved   = r_flags_saved;
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed test-plan scenarios plus random traffic, checked
// every cycle against an action-queue reference model.
module tb_irq_sequencer;
   localparam int W = 16, PC_W = 32, VEC_ADDR = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0, errors = 0;
   irq_sequencer_if #(.W(W), .PC_W(PC_W)) bus ();
   irq_sequencer #(.W(W), .PC_W(PC_W), .VEC_ADDR(VEC_ADDR)) dut (.clk(clk), .rst(rst), .io_bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   // model: queue of actions still owed after acceptance (1=push hi, 2=push lo, 3=vector)
   int q[$];
   bit m_pend, m_prev, m_isr, m_acc;
   logic [31:0] m_ret;
   logic [2:0] m_fl;
   logic e_ack, e_hold, e_iv, e_vl, e_isr, e_fr;
   logic [1:0] e_op;
   logic [15:0] e_pd;
   logic [31:0] e_va;
   task automatic model_eval();
      {e_ack, e_hold, e_iv, e_vl, e_isr, e_fr} = '0;
      e_op = 2'b00; e_pd = 16'h0; e_va = 32'h0; m_acc = 1'b0;
      if (q.size() > 0) begin
         e_iv = 1'b1;
         if (q[0] == 3) begin
            e_vl = 1'b1; e_va = 32'(VEC_ADDR);
         end else begin
            e_hold = 1'b1; e_op = 2'(q[0]);
            e_pd = (q[0] == 1) ? m_ret / 65536 : m_ret % 65536;
         end
      end else if (m_isr) begin
         e_isr = 1'b1; e_fr = bus.rti;
      end else begin
         m_acc = m_pend && !bus.branch_pending && !bus.stall;
         e_ack = m_acc; e_hold = m_acc; e_iv = m_acc;
      end
   endtask
   task automatic model_edge();
      bit rise;
      if (rst) begin
         q.delete(); m_pend = 0; m_prev = 0; m_isr = 0; m_ret = '0; m_fl = '0;
      end else begin
         rise = bus.interrupt && !m_prev;
         if (q.size() > 0) begin
            if (q[0] == 3 || !bus.stall) begin
               if (q[0] == 3) m_isr = 1;
               void'(q.pop_front());
            end
         end else if (m_isr) begin
            if (bus.rti) m_isr = 0;
         end else if (m_acc) begin
            q = '{1, 2, 3}; m_ret = bus.fetch_pc; m_fl = bus.flags;
         end
         m_pend = rise || (m_pend && !m_acc);
         m_prev = bus.interrupt;
      end
   endtask
   task automatic step();
      #3;
      model_eval();
      chk("irq_ack", 64'(bus.irq_ack), 64'(e_ack));
      chk("pc_hold", 64'(bus.pc_hold), 64'(e_hold));
      chk("inject_valid", 64'(bus.inject_valid), 64'(e_iv));
      chk("inject_op", 64'(bus.inject_op), 64'(e_op));
      chk("push_data", 64'(bus.push_data), 64'(e_pd));
      chk("vector_load", 64'(bus.vector_load), 64'(e_vl));
      chk("vector_addr", 64'(bus.vector_addr), 64'(e_va));
      chk("in_isr", 64'(bus.in_isr), 64'(e_isr));
      chk("flags_restore", 64'(bus.flags_restore), 64'(e_fr));
      chk("flags_saved", 64'(bus.flags_saved), 64'(m_fl));
      @(posedge clk);
      model_edge();
      #1;
   endtask
   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask
   function automatic logic [63:0] all_outs();
      return 64'({bus.pc_hold, bus.inject_valid, bus.inject_op, bus.push_data, bus.vector_load,
                  bus.irq_ack, bus.in_isr, bus.flags_restore, bus.flags_saved}) | 64'(bus.vector_addr);
   endfunction
   initial begin
      bus.interrupt = 0; bus.fetch_pc = '0; bus.branch_pending = 0;
      bus.stall = 0; bus.flags = '0; bus.rti = 0;
      @(posedge clk); model_edge(); #1;
      steps(2);
      rst = 0;
      #1 chk("reset_outs", all_outs(), 64'h0);
      // basic latency scenario
      bus.interrupt = 1; bus.fetch_pc = 32'h40; bus.flags = 3'b101; step();
      #1 chk("tp_ack", {bus.irq_ack, bus.inject_valid, bus.inject_op}, 64'b1100); step();
      #1 chk("tp_hi", {bus.inject_op, bus.push_data}, {2'b01, 16'h0000}); step();
      #1 chk("tp_lo", {bus.inject_op, bus.push_data}, {2'b10, 16'h0040}); step();
      #1 chk("tp_vec", {bus.vector_load, bus.vector_addr}, {1'b1, 32'd2}); step();
      #1 chk("tp_isr", 64'(bus.in_isr), 64'd1);
      bus.flags = 3'b010; steps(4);
      bus.rti = 1;
      #1 chk("tp_restore", {bus.flags_restore, bus.flags_saved}, {1'b1, 3'b101}); step();
      bus.rti = 0;
      // branch_pending delays acceptance
      bus.interrupt = 0; step();
      bus.interrupt = 1; bus.branch_pending = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("bp_noack", 64'(bus.irq_ack), 64'd0); step();
      end
      bus.branch_pending = 0; bus.fetch_pc = 32'h1234;
      #1 chk("bp_ack", 64'(bus.irq_ack), 64'd1); step();
      #1 chk("bp_hi", 64'(bus.push_data), 64'h0000); step();
      #1 chk("bp_lo", 64'(bus.push_data), 64'h1234); step();
      steps(2);
      bus.rti = 1; step(); bus.rti = 0;
      // stall while in PUSH_LO
      bus.interrupt = 0; step();
      bus.interrupt = 1; bus.fetch_pc = 32'h0001_0008; steps(3);
      bus.stall = 1;
      for (int i = 0; i < 2; i++) begin
         #1 chk("stall_lo", {bus.inject_op, bus.push_data}, {2'b10, 16'h0008}); step();
      end
      bus.stall = 0;
      #1 chk("stall_lo_end", {bus.inject_op, bus.push_data}, {2'b10, 16'h0008}); step();
      #1 chk("stall_vec", 64'(bus.vector_load), 64'd1); step();
      #1 chk("stall_vec_once", 64'(bus.vector_load), 64'd0); step();
      // edge during ISR is deferred until after rti
      bus.interrupt = 0; step();
      bus.interrupt = 1; steps(2);
      #1 chk("isr_noack", 64'(bus.irq_ack), 64'd0);
      bus.rti = 1; step(); bus.rti = 0;
      #1 chk("isr_deferred_ack", 64'(bus.irq_ack), 64'd1); steps(5);
      bus.rti = 1; step(); bus.rti = 0;
      for (int i = 0; i < 6; i++) begin
         #1 chk("held_noack", 64'(bus.irq_ack), 64'd0); step();
      end
      // reset in PUSH_HI
      bus.interrupt = 0; step();
      bus.interrupt = 1; steps(2);
      rst = 1; bus.interrupt = 0; step(); rst = 0;
      #1 chk("rst_mid_outs", all_outs(), 64'h0);
      for (int i = 0; i < 8; i++) begin
         #1 chk("rst_no_vec", 64'(bus.vector_load), 64'd0); step();
      end
      // new edge on the acceptance cycle keeps pending
      bus.interrupt = 1; bus.branch_pending = 1; step();
      bus.interrupt = 0; step();
      bus.interrupt = 1; bus.branch_pending = 0;
      #1 chk("same_acc", 64'(bus.irq_ack), 64'd1); steps(5);
      bus.rti = 1; step(); bus.rti = 0;
      #1 chk("same_second_ack", 64'(bus.irq_ack), 64'd1); steps(5);
      bus.rti = 1; step(); bus.rti = 0;
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) bus.interrupt = ~bus.interrupt;
         bus.fetch_pc = $urandom;
         bus.branch_pending = ($urandom_range(0, 3) == 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.flags = 3'($urandom);
         bus.rti = ($urandom_range(0, 7) == 0);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
